alu_arbiter: RTL and testbench

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_arbiter.sv | 128 ++++++++++++
 tb/tb_alu_arbiter.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// alu_arbiter: two-requester round-robin front end for a single shared ALU.
// One operation in flight at a time. It is granted in IDLE, driven onto the
// ALU in ISSUE, held in CAPTURE while the ALU's registered carry settles, and
// returned to the consumer in RESP with valid/ready handshaking.
//
// Ports
//   clk, rst_n                   clock, async active-low reset
//   reqN_valid / reqN_ready      request handshake (ready is combinational, IDLE only)
//   reqN_a/b/op/sh_amt/shift_src request operands
//   alu_a/b/op/sh_amt/shift_src  registered operands to the shared ALU
//   alu_result/neg/zero/carry    ALU outputs (carry is registered inside the ALU)
//   rsp_valid / rsp_ready        response handshake
//   rsp_id/result/neg/zero/carry captured response
module alu_arbiter #(
  parameter bit FIRST_PRIO = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0_valid,
  input  logic        req1_valid,
  output logic        req0_ready,
  output logic        req1_ready,
  input  logic [31:0] req0_a,
  input  logic [31:0] req1_a,
  input  logic [31:0] req0_b,
  input  logic [31:0] req1_b,
  input  logic [2:0]  req0_op,
  input  logic [2:0]  req1_op,
  input  logic [4:0]  req0_sh_amt,
  input  logic [4:0]  req1_sh_amt,
  input  logic        req0_shift_src,
  input  logic        req1_shift_src,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [2:0]  alu_op,
  output logic [4:0]  alu_sh_amt,
  output logic        alu_shift_src,
  input  logic [31:0] alu_result,
  input  logic        alu_neg,
  input  logic        alu_zero,
  input  logic        alu_carry,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_id,
  output logic [31:0] rsp_result,
  output logic        rsp_neg,
  output logic        rsp_zero,
  output logic        rsp_carry
);

  typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, RESP} state_t;

  state_t state, state_nxt;
  logic   prio;     // requester that wins a tie
  logic   owner;    // requester of the operation in flight
  logic   gnt_any;
  logic   gnt_id;
  logic   grant;

  // Tie goes to prio; otherwise whichever one is asking.
  always_comb begin
    gnt_any = req0_valid | req1_valid;
    gnt_id  = (req0_valid & req1_valid) ? prio : req1_valid;
  end

  // Gated by rst_n so no grant is visible while reset is held.
  assign grant      = rst_n && (state == IDLE) && gnt_any;
  assign req0_ready = grant && !gnt_id;
  assign req1_ready = grant &&  gnt_id;
  assign rsp_valid  = (state == RESP);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (gnt_any) state_nxt = ISSUE;
      ISSUE:   state_nxt = CAPTURE;
      CAPTURE: state_nxt = RESP;
      RESP:    if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Operands are loaded only on a grant, so the ALU inputs hold steady through
  // CAPTURE, RESP and the following IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prio          <= FIRST_PRIO;
      owner         <= 1'b0;
      alu_a         <= '0;
      alu_b         <= '0;
      alu_op        <= '0;
      alu_sh_amt    <= '0;
      alu_shift_src <= 1'b0;
    end else if (state == IDLE && gnt_any) begin
      prio          <= ~gnt_id;
      owner         <= gnt_id;
      alu_a         <= gnt_id ? req1_a         : req0_a;
      alu_b         <= gnt_id ? req1_b         : req0_b;
      alu_op        <= gnt_id ? req1_op        : req0_op;
      alu_sh_amt    <= gnt_id ? req1_sh_amt    : req0_sh_amt;
      alu_shift_src <= gnt_id ? req1_shift_src : req0_shift_src;
    end
  end

  // Capture at the end of CAPTURE: by then the ALU's registered carry reflects
  // the operands issued one edge earlier.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_id     <= 1'b0;
      rsp_result <= '0;
      rsp_neg    <= 1'b0;
      rsp_zero   <= 1'b0;
      rsp_carry  <= 1'b0;
    end else if (state == CAPTURE) begin
      rsp_id     <= owner;
      rsp_result <= alu_result;
      rsp_neg    <= alu_neg;
      rsp_zero   <= alu_zero;
      rsp_carry  <= alu_carry;
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
module tb_alu_arbiter;
  localparam logic [2:0] OP_ADD = 3'd0, OP_SUB = 3'd1, OP_AND = 3'd2,
                         OP_SHL = 3'd5, OP_SHR = 3'd6;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0_valid, req1_valid, req0_ready, req1_ready;
  logic [31:0] req0_a, req1_a, req0_b, req1_b;
  logic [2:0]  req0_op, req1_op;
  logic [4:0]  req0_sh_amt, req1_sh_amt;
  logic        req0_shift_src, req1_shift_src;
  logic [31:0] alu_a, alu_b, alu_result;
  logic [2:0]  alu_op;
  logic [4:0]  alu_sh_amt;
  logic        alu_shift_src, alu_neg, alu_zero, alu_carry;
  logic        rsp_valid, rsp_ready, rsp_id, rsp_neg, rsp_zero, rsp_carry;
  logic [31:0] rsp_result;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  alu_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req1_valid(req1_valid),
    .req0_ready(req0_ready), .req1_ready(req1_ready),
    .req0_a(req0_a), .req1_a(req1_a), .req0_b(req0_b), .req1_b(req1_b),
    .req0_op(req0_op), .req1_op(req1_op),
    .req0_sh_amt(req0_sh_amt), .req1_sh_amt(req1_sh_amt),
    .req0_shift_src(req0_shift_src), .req1_shift_src(req1_shift_src),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_sh_amt(alu_sh_amt), .alu_shift_src(alu_shift_src),
    .alu_result(alu_result), .alu_neg(alu_neg), .alu_zero(alu_zero),
    .alu_carry(alu_carry),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_result(rsp_result), .rsp_neg(rsp_neg), .rsp_zero(rsp_zero),
    .rsp_carry(rsp_carry)
  );

  // Behavioural ALU: combinational result/flags, carry registered on clk.
  logic [4:0]  sh;
  logic [32:0] sum;
  logic        c_nxt;
  always_comb begin
    sh         = alu_shift_src ? alu_b[4:0] : alu_sh_amt;
    sum        = {1'b0, alu_a} + {1'b0, alu_b};
    c_nxt      = 1'b0;
    alu_result = alu_a ^ alu_b;
    case (alu_op)
      OP_ADD: begin alu_result = sum[31:0]; c_nxt = sum[32]; end
      OP_SUB: begin alu_result = alu_a - alu_b; c_nxt = (alu_a < alu_b); end
      OP_AND: alu_result = alu_a & alu_b;
      OP_SHL: alu_result = alu_a << sh;
      OP_SHR: alu_result = alu_a >> sh;
      default: ;
    endcase
    alu_neg  = alu_result[31];
    alu_zero = (alu_result == 32'd0);
  end
  always @(posedge clk) alu_carry <= c_nxt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; rsp_ready = 1'b0;
    req0_valid = 1'b1; req1_valid = 1'b0;
    req0_a = '0; req0_b = '0; req0_op = '0; req0_sh_amt = '0; req0_shift_src = 1'b0;
    req1_a = '0; req1_b = '0; req1_op = '0; req1_sh_amt = '0; req1_shift_src = 1'b0;

    // Reset state, with a request pending that must not be granted.
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req0_ready", 32'(req0_ready), 0);
    chk("rst_rsp_valid",  32'(rsp_valid), 0);
    chk("rst_rsp_result", rsp_result, 0);
    chk("rst_alu_a",      alu_a, 0);

    @(negedge clk);
    rst_n = 1'b1; req0_valid = 1'b0;

    // Single op: 5 + 3 from req0.
    @(negedge clk);
    req0_valid = 1'b1; req0_a = 32'd5; req0_b = 32'd3; req0_op = OP_ADD;
    #1;
    chk("single_req0_ready", 32'(req0_ready), 1);
    chk("single_req1_ready", 32'(req1_ready), 0);
    @(posedge clk); #1;
    req0_valid = 1'b0;
    chk("issue_req0_ready", 32'(req0_ready), 0);
    chk("issue_alu_a", alu_a, 5);
    chk("issue_alu_b", alu_b, 3);
    chk("issue_rsp_valid", 32'(rsp_valid), 0);
    @(posedge clk); #1;
    chk("capture_rsp_valid", 32'(rsp_valid), 0);
    chk("capture_alu_a", alu_a, 5);
    @(posedge clk); #1;
    chk("single_rsp_valid",  32'(rsp_valid), 1);
    chk("single_rsp_result", rsp_result, 8);
    chk("single_rsp_id",     32'(rsp_id), 0);
    chk("single_rsp_zero",   32'(rsp_zero), 0);
    chk("single_rsp_neg",    32'(rsp_neg), 0);
    chk("single_rsp_carry",  32'(rsp_carry), 0);

    // Backpressure: req1 waits while the response is held.
    req1_valid = 1'b1; req1_a = 32'hFFFF_FFFF; req1_b = 32'd1; req1_op = OP_ADD;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_req0_ready", 32'(req0_ready), 0);
      chk("bp_req1_ready", 32'(req1_ready), 0);
      @(posedge clk); #1;
      chk("bp_rsp_valid",  32'(rsp_valid), 1);
      chk("bp_rsp_result", rsp_result, 8);
      chk("bp_rsp_id",     32'(rsp_id), 0);
    end
    @(negedge clk);
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_release_valid", 32'(rsp_valid), 0);
    chk("carry_req1_ready", 32'(req1_ready), 1);

    // Carry capture from req1; rsp_ready high outside RESP is ignored.
    @(posedge clk); #1;
    req1_valid = 1'b0;
    chk("carry_alu_a", alu_a, 32'hFFFF_FFFF);
    chk("carry_issue_ready", 32'(req1_ready), 0);
    @(posedge clk); #1;
    chk("carry_capture_valid", 32'(rsp_valid), 0);
    rsp_ready = 1'b0;
    @(posedge clk); #1;
    chk("carry_rsp_valid",  32'(rsp_valid), 1);
    chk("carry_rsp_result", rsp_result, 0);
    chk("carry_rsp_zero",   32'(rsp_zero), 1);
    chk("carry_rsp_carry",  32'(rsp_carry), 1);
    chk("carry_rsp_id",     32'(rsp_id), 1);
    chk("carry_rsp_neg",    32'(rsp_neg), 0);
    @(posedge clk); #1;
    chk("carry_held_valid", 32'(rsp_valid), 1);
    @(negedge clk);
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    chk("carry_release_valid", 32'(rsp_valid), 0);

    // Fairness: both valid, rsp_ready held high; grants alternate 0,1,0,1.
    req0_a = 32'd10; req0_b = 32'd1; req0_op = OP_ADD;
    req1_a = 32'd20; req1_b = 32'd2; req1_op = OP_SUB;
    req0_valid = 1'b1; req1_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("fair_req0_ready", 32'(req0_ready), (i % 2 == 0) ? 1 : 0);
      chk("fair_req1_ready", 32'(req1_ready), (i % 2 == 1) ? 1 : 0);
      @(posedge clk); #1;
      chk("fair_issue_valid", 32'(rsp_valid), 0);
      @(posedge clk); #1;
      @(posedge clk); #1;
      chk("fair_rsp_valid",  32'(rsp_valid), 1);
      chk("fair_rsp_id",     32'(rsp_id), i % 2);
      chk("fair_rsp_result", rsp_result, (i % 2 == 1) ? 18 : 11);
      @(posedge clk); #1;
    end
    req0_valid = 1'b0; req1_valid = 1'b0;

    // Shift source: amount from b[4:0], sh_amt=7 must be ignored.
    req0_valid = 1'b1; req0_a = 32'd1; req0_b = 32'd4; req0_op = OP_SHL;
    req0_sh_amt = 5'd7; req0_shift_src = 1'b1;
    #1;
    chk("shift_req0_ready", 32'(req0_ready), 1);
    @(posedge clk); #1;
    req0_valid = 1'b0;
    chk("shift_alu_sh_amt", 32'(alu_sh_amt), 7);
    chk("shift_alu_src",    32'(alu_shift_src), 1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("shift_rsp_result", rsp_result, 16);
    chk("shift_rsp_id",     32'(rsp_id), 0);
    @(posedge clk); #1;
    chk("shift_release_valid", 32'(rsp_valid), 0);

    // Mid-operation reset during CAPTURE (pointer now favours req1).
    req0_valid = 1'b1; req0_a = 32'd3; req0_b = 32'd3; req0_op = OP_ADD;
    req0_sh_amt = 5'd0; req0_shift_src = 1'b0;
    #1;
    chk("midrst_req0_ready", 32'(req0_ready), 1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("midrst_alu_a_before", alu_a, 3);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_rsp_valid",  32'(rsp_valid), 0);
    chk("midrst_rsp_result", rsp_result, 0);
    chk("midrst_alu_a",      alu_a, 0);
    chk("midrst_alu_b",      alu_b, 0);
    chk("midrst_req0_ready", 32'(req0_ready), 0);
    @(posedge clk); #1;
    chk("midrst_held_ready", 32'(req0_ready), 0);
    chk("midrst_held_valid", 32'(rsp_valid), 0);
    req0_valid = 1'b0; req1_valid = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("post_rst_req1_ready", 32'(req1_ready), 1);
    chk("post_rst_req0_ready", 32'(req0_ready), 0);
    req0_valid = 1'b1;
    #1;
    chk("post_rst_tie_req0", 32'(req0_ready), 1);
    chk("post_rst_tie_req1", 32'(req1_ready), 0);
    @(posedge clk); #1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("post_rst_rsp_valid",  32'(rsp_valid), 1);
    chk("post_rst_rsp_id",     32'(rsp_id), 0);
    chk("post_rst_rsp_result", rsp_result, 6);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
